reg_alu_seq: RTL

REG_ALU_SEQ -- requirements
Module: reg_alu_seq

---
 rtl/reg_alu_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: sequential ALU with a valid/ready handshake on both sides.
// A request is captured when in_valid and in_ready are both high. Single-cycle
// opcodes produce a registered result one edge later. Optional shift-add
// multiply (opcode 1001) is built only when REG_ALU_MUL_EN is defined.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   instruction[3:0]  opcode
//   A, B [WIDTH-1:0]  operands
//   in_valid/in_ready request handshake
//   X [WIDTH-1:0]     registered result
//   flags[3:0]        {carry, overflow, negative, zero}
//   err               unsupported opcode
//   out_valid/out_ready result handshake
//
// Macro: REG_ALU_MUL_EN enables the multi-cycle multiply and the BUSY state.
module reg_alu_seq #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       instruction,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] X,
   output logic [3:0]       flags,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready
);

`ifdef REG_ALU_MUL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   localparam int CW = $clog2(WIDTH) + 1;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [3:0]       flags_q, flags_d;
   logic             err_q, err_d;

   logic             accept;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] res_x;
   logic             res_c, res_v, res_err;

`ifdef REG_ALU_MUL_EN
   logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_nxt;
`endif

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign X         = x_q;
   assign flags     = flags_q;
   assign err       = err_q;

   // Single-cycle datapath; the extra MSB of sum/diff is carry-out / borrow.
   assign sum  = {1'b0, A} + {1'b0, B};
   assign diff = {1'b0, A} - {1'b0, B};

   always_comb begin
      res_x   = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      res_err = 1'b0;
      case (instruction)
         4'b0000: res_x = A;
         4'b0001: begin
            res_x = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (A[WIDTH-1] == B[WIDTH-1]) && (res_x[WIDTH-1] != A[WIDTH-1]);
         end
         4'b0010: begin
            res_x = diff[WIDTH-1:0];
            res_c = diff[WIDTH];
            res_v = (A[WIDTH-1] != B[WIDTH-1]) && (res_x[WIDTH-1] != A[WIDTH-1]);
         end
         4'b0011: res_x = A & B;
         4'b0100: res_x = A | B;
         4'b0101: res_x = A ^ B;
         4'b0110: res_x = ~A;
         4'b0111: begin
            res_x = {A[WIDTH-2:0], 1'b0};
            res_c = A[WIDTH-1];
         end
         4'b1000: begin
            res_x = {1'b0, A[WIDTH-1:1]};
            res_c = A[0];
         end
         default: res_err = 1'b1;
      endcase
   end

`ifdef REG_ALU_MUL_EN
   // One multiplier bit per BUSY cycle; the last step's sum is the product.
   assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      flags_d = flags_q;
      err_d   = err_q;
`ifdef REG_ALU_MUL_EN
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
`ifdef REG_ALU_MUL_EN
               if (instruction == 4'b1001) begin
                  state_d  = BUSY;
                  prod_d   = '0;
                  mcand_d  = {{WIDTH{1'b0}}, A};
                  mplier_d = B;
                  cnt_d    = '0;
               end else
`endif
               begin
                  state_d = DONE;
                  x_d     = res_x;
                  err_d   = res_err;
                  // An unsupported opcode reports all-zero flags, including zero.
                  flags_d = res_err ? 4'b0000 :
                            {res_c, res_v, res_x[WIDTH-1], (res_x == '0)};
               end
            end else if (state_q == DONE && out_ready) begin
               state_d = IDLE;
            end
         end
`ifdef REG_ALU_MUL_EN
         BUSY: begin
            prod_d   = prod_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               x_d     = prod_nxt[WIDTH-1:0];
               err_d   = 1'b0;
               flags_d = {(prod_nxt[2*WIDTH-1:WIDTH] != '0), 1'b0,
                          prod_nxt[WIDTH-1], (prod_nxt[WIDTH-1:0] == '0)};
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         flags_q <= '0;
         err_q   <= 1'b0;
`ifdef REG_ALU_MUL_EN
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         flags_q <= flags_d;
         err_q   <= err_d;
`ifdef REG_ALU_MUL_EN
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

endmodule
